// File: rtl/dekatron_step_ctrl_if.sv
// Request/operand bundle and tube-drive outputs of dekatron_step_ctrl.
// The slave modport is the sequencer side; master is the register-logic side.
interface dekatron_step_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  Request;
    logic [1:0]            Op;
    logic [4*DIGITS-1:0]   In;
    logic                  Ready;
    logic                  Busy;
    logic [DIGITS-1:0]     Guide1;
    logic [DIGITS-1:0]     Guide2;
    logic [10*DIGITS-1:0]  Pos;
    logic [4*DIGITS-1:0]   Out;
    logic                  Zero;
    logic                  Carry;

    modport master (
        output Request, Op, In,
        input  Ready, Busy, Guide1, Guide2, Pos, Out, Zero, Carry
    );

    modport slave (
        input  Request, Op, In,
        output Ready, Busy, Guide1, Guide2, Pos, Out, Zero, Carry
    );
endinterface

// File: rtl/dekatron_step_ctrl.sv
// Two-phase guide-pulse sequencer for a chain of one-hot dekatron tubes (INC/DEC/LOAD/CLEAR).
// Define DEKATRON_SHORTEST_EN to let LOAD/CLEAR step each tube along its shortest path.
module dekatron_step_ctrl #(
    parameter int DIGITS  = 4,
    parameter int PULSE_W = 2
) (
    input logic                 Clk,
    input logic                 Rst_n,
    dekatron_step_ctrl_if.slave bus
);
    localparam int              DW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0]   LAST_DIGIT = DW'(DIGITS - 1);
    localparam logic [3:0]      LAST_PHASE = 4'(PULSE_W - 1);
    localparam logic [1:0]      OP_INC     = 2'b00;
    localparam logic [1:0]      OP_DEC     = 2'b01;
    localparam logic [1:0]      OP_CLEAR   = 2'b11;

    typedef enum logic [2:0] {IDLE, SCAN, PH_A, PH_B, EVAL} state_t;

    state_t                    state_q, state_d;
    logic [DW-1:0]             digit_q, digit_d;
    logic                      fwd_q, fwd_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [4*DIGITS-1:0]       target_q, target_d;
    logic                      incdec_q, incdec_d;
    logic                      wrap_q, wrap_d;
    logic [DIGITS-1:0][9:0]    pos_q, pos_d;
    logic [DIGITS-1:0]         guide1_q, guide1_d;
    logic [DIGITS-1:0]         guide2_q, guide2_d;

    logic [DIGITS-1:0][3:0]    bcd;
    logic [DIGITS-1:0]         at_zero;
    logic [3:0]                cur_val;
    logic [3:0]                tgt_val;
    logic                      match;
    logic                      step_fwd;

    function automatic logic [3:0] onehot_to_bcd(input logic [9:0] p);
        logic [3:0] v;
        v = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (p[i]) begin
                v = v | 4'(i);
            end
        end
        return v;
    endfunction

    always_comb begin
        for (int d = 0; d < DIGITS; d++) begin
            bcd[d]     = onehot_to_bcd(pos_q[d]);
            at_zero[d] = pos_q[d][0];
        end
    end

    // A target nibble above 9 is treated as already reached so that tube is left alone.
    always_comb begin
        cur_val = bcd[digit_q];
        tgt_val = target_q[4*digit_q +: 4];
        match   = (cur_val == tgt_val) || (tgt_val > 4'd9);
    end

`ifdef DEKATRON_SHORTEST_EN
    logic [4:0] dist;
    always_comb begin
        dist = 5'(tgt_val) + 5'd10 - 5'(cur_val);
        if (dist >= 5'd10) begin
            dist = dist - 5'd10;
        end
        step_fwd = (dist <= 5'd5);
    end
`else
    always_comb begin
        step_fwd = 1'b1;
    end
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            digit_q  <= '0;
            fwd_q    <= 1'b1;
            cnt_q    <= '0;
            target_q <= '0;
            incdec_q <= 1'b0;
            wrap_q   <= 1'b0;
            guide1_q <= '0;
            guide2_q <= '0;
            for (int d = 0; d < DIGITS; d++) begin
                pos_q[d] <= 10'd1;
            end
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            fwd_q    <= fwd_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            incdec_q <= incdec_d;
            wrap_q   <= wrap_d;
            guide1_q <= guide1_d;
            guide2_q <= guide2_d;
            pos_q    <= pos_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        fwd_d    = fwd_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        incdec_d = incdec_q;
        wrap_d   = wrap_q;
        pos_d    = pos_q;
        case (state_q)
            IDLE: begin
                if (bus.Request) begin
                    incdec_d = (bus.Op == OP_INC) || (bus.Op == OP_DEC);
                    target_d = (bus.Op == OP_CLEAR) ? '0 : bus.In;
                    digit_d  = '0;
                    cnt_d    = '0;
                    if ((bus.Op == OP_INC) || (bus.Op == OP_DEC)) begin
                        fwd_d   = (bus.Op == OP_INC);
                        state_d = PH_A;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!match) begin
                    fwd_d   = step_fwd;
                    cnt_d   = '0;
                    state_d = PH_A;
                end else if (digit_q == LAST_DIGIT) begin
                    state_d = IDLE;
                end else begin
                    digit_d = digit_q + 1'b1;
                end
            end
            PH_A: begin
                if (cnt_q == LAST_PHASE) begin
                    cnt_d   = '0;
                    state_d = PH_B;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The tube physically advances as guide 2 (or guide 1 backwards) releases.
            PH_B: begin
                if (cnt_q == LAST_PHASE) begin
                    cnt_d   = '0;
                    state_d = EVAL;
                    if (fwd_q) begin
                        pos_d[digit_q] = {pos_q[digit_q][8:0], pos_q[digit_q][9]};
                        wrap_d         = pos_q[digit_q][9];
                    end else begin
                        pos_d[digit_q] = {pos_q[digit_q][0], pos_q[digit_q][9:1]};
                        wrap_d         = pos_q[digit_q][0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EVAL: begin
                if (!incdec_q) begin
                    state_d = SCAN;
                end else if (wrap_q && (digit_q != LAST_DIGIT)) begin
                    digit_d = digit_q + 1'b1;
                    state_d = PH_A;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Guides are decoded from the next state so the registered pulses line up with PH_A/PH_B.
    always_comb begin
        guide1_d = '0;
        guide2_d = '0;
        if ((state_d == PH_A) || (state_d == PH_B)) begin
            if ((state_d == PH_A) == fwd_d) begin
                guide1_d[digit_d] = 1'b1;
            end else begin
                guide2_d[digit_d] = 1'b1;
            end
        end
    end

    assign bus.Ready  = (state_q == IDLE);
    assign bus.Busy   = (state_q != IDLE);
    assign bus.Guide1 = guide1_q;
    assign bus.Guide2 = guide2_q;
    assign bus.Pos    = pos_q;
    assign bus.Zero   = &at_zero;
    assign bus.Carry  = (state_q == EVAL) && incdec_q && wrap_q && (digit_q == LAST_DIGIT);

    for (genvar d = 0; d < DIGITS; d++) begin : g_out
        assign bus.Out[4*d +: 4] = bcd[d];
    end
endmodule

// File: doc/dekatron_step_ctrl.md
Name: dekatron_step_ctrl

Overview:
Sequencer for a chain of DIGITS dekatron counting tubes. Each tube is modelled as a one-hot 10-position state. The block generates the two-phase guide pulses (Guide1/Guide2) that physically step each tube, and performs INC/DEC with decimal ripple carry, LOAD of a BCD value, and CLEAR. It exposes the current value both as one-hot positions and as 8-4-2-1 BCD, and sits between the machine's register logic and the tube drivers.

Parameters:
DIGITS, 4, number of dekatron tubes (decades); digit 0 is least significant.
PULSE_W, 2, clock cycles per guide phase (1..15).

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Request  in  1  start operation; sampled only while Ready=1
Op  in  2  00 INC, 01 DEC, 10 LOAD, 11 CLEAR
In  in  4*DIGITS  BCD load value, digit d at [4d+3:4d]
Ready  out  1  idle, accepts Request
Busy  out  1  equals ~Ready
Guide1  out  DIGITS  guide-1 pulse per tube
Guide2  out  DIGITS  guide-2 pulse per tube
Pos  out  10*DIGITS  one-hot position per tube, digit d at [10d+9:10d]
Out  out  4*DIGITS  BCD of Pos (combinational from Pos)
Zero  out  1  all tubes at position 0
Carry  out  1  one-cycle pulse: INC wrapped top digit 9->0, or DEC borrowed top digit 0->9

Behaviour:
- Reset, asynchronous and active-low, applies immediately, including mid-operation:
  - every Pos = position 0; Out=0; Zero=1; Ready=1; Busy=0; Guide1=Guide2=0; Carry=0; state IDLE; digit index 0.
- Pos holds exactly one hot bit per tube at all times.
- States: IDLE, SCAN, PH_A, PH_B, EVAL. Registers: digit index, direction, phase counter, latched target.
- IDLE:
  - Request=1 at a rising edge → Ready drops next cycle; In and Op are latched.
  - INC/DEC go to PH_A with digit 0. LOAD/CLEAR go to SCAN with digit 0; CLEAR uses a target of all zeros.
- SCAN (1 cycle):
  - Current digit ≠ target digit → PH_A, direction forward.
  - Else, if last digit → IDLE. Otherwise advance the digit and stay in SCAN.
  - A target nibble >9 counts as a match: that digit is left unchanged.
- PH_A / PH_B (PULSE_W cycles each):
  - Forward: PH_A drives Guide1[d], PH_B drives Guide2[d]. Backward: PH_A drives Guide2[d], PH_B drives Guide1[d].
  - Only the selected tube's bit is driven; all others stay 0. Guides are registered; the two never overlap.
  - Pos[d] rotates one position (9→0 forward, 0→9 backward) on the final PH_B edge.
- EVAL (1 cycle):
  - LOAD/CLEAR → SCAN, same digit.
  - INC/DEC where the step wrapped and d<DIGITS-1 → digit+1, then PH_A.
  - INC/DEC where the step wrapped and d=DIGITS-1 → Carry=1 this cycle, then IDLE.
  - INC/DEC with no wrap → IDLE.
- Latency (Busy cycles):
  - INC/DEC: k*(2*PULSE_W+1), where k is the number of digits stepped.
  - LOAD/CLEAR (forward-only build): DIGITS + S*(2*PULSE_W+2), where S is the total number of steps.
- Ready returns high the cycle after the final state. Request while Busy is ignored, not queued.
- Zero and Out are combinational from Pos.

Optional Feature:
DEKATRON_SHORTEST_EN:
- Defined: in SCAN, LOAD/CLEAR pick the direction per digit by shortest path. Forward if (target−current) mod 10 ≤ 5, else backward; this gives at most 5 steps per digit.
- Undefined: always forward (up to 9 steps per digit).
- INC/DEC are unaffected in either build.

Test Plan:
- Reset, then DIGITS=2, PULSE_W=2, INC → Busy for 5 cycles; Guide1[0] high 2 cycles then Guide2[0] high 2 cycles; Out=01; Carry=0.
- Out=09, INC → 2 digit steps, 10 busy cycles, Out=10, Guide pulses on tube 0 then tube 1.
- Out=99, INC → Out=00, Zero=1, Carry pulses 1 cycle; DEC from 00 → Out=99, Carry pulses; phase order Guide2 then Guide1.
- Forward build, LOAD In=0x37 from 00 → 62 busy cycles, Out=37. Shortest build → digit 0 takes 3 backward steps and digit 1 takes 3 forward steps, 38 busy cycles.
- LOAD In=0xF2 from 00 → digit 0 becomes 2, digit 1 stays 0 (Out=02); CLEAR from 58 → Out=00, Zero=1.
- Assert Rst_n=0 during PH_A of a LOAD → Guides drop immediately, Out=00, Ready=1; Request while Busy → no effect on the result.
